dbus_demux_1to2: RTL

- Routes one upstream data-bus request from the core's load/store unit to one of two downstream targets: port 0 (data RAM, default target) or port 1 (MMIO window).
- Steers the selected target's read data and completion back upstream.
- Holds at most one transaction outstanding, with valid/ready handshakes on every channel.
- Adds misalignment and timeout error reporting so a dead target cannot hang the core.

---
 rtl/dbus_pkg.sv | 17 +
 rtl/dbus_addr_decode.sv | 16 +
 rtl/dbus_demux_1to2.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types and constants for the data-bus demux
package dbus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/dbus_addr_decode.sv
// rtl/dbus_addr_decode.sv - combinational match of an address against a power-of-two window
import dbus_pkg::*;

module dbus_addr_decode #(
  parameter logic [ADDR_W-1:0] BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SIZE = 32'h0001_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              sel
);

  localparam logic [ADDR_W-1:0] MASK = ~(SIZE - 32'd1);

  assign sel = ((addr & MASK) == BASE);

endmodule

// File: rtl/dbus_demux_1to2.sv
// rtl/dbus_demux_1to2.sv - one-outstanding demux of a core data bus onto RAM (port 0) and MMIO (port 1)
import dbus_pkg::*;

module dbus_demux_1to2 #(
  parameter logic [ADDR_W-1:0] P1_BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] P1_SIZE = 32'h0001_0000,
  parameter int                TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              d0_valid,
  input  logic              d0_ready,
  output logic [ADDR_W-1:0] d0_addr,
  output logic              d0_we,
  output logic [DATA_W-1:0] d0_wdata,
  output logic [STRB_W-1:0] d0_wstrb,
  input  logic              d0_rvalid,
  input  logic [DATA_W-1:0] d0_rdata,
  output logic              d1_valid,
  input  logic              d1_ready,
  output logic [ADDR_W-1:0] d1_addr,
  output logic              d1_we,
  output logic [DATA_W-1:0] d1_wdata,
  output logic [STRB_W-1:0] d1_wstrb,
  input  logic              d1_rvalid,
  input  logic [DATA_W-1:0] d1_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              sel_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              sel;
  logic              misaligned;
  logic              timeout;
  logic              sel_ready;
  logic              sel_rvalid;
  logic [DATA_W-1:0] sel_rdata;

  dbus_addr_decode #(
    .BASE (P1_BASE),
    .SIZE (P1_SIZE)
  ) u_decode (
    .addr (req_addr),
    .sel  (sel)
  );

  assign misaligned = (req_addr[1:0] != 2'b00);
  assign timeout    = (cnt == CNT_LAST);
  assign sel_ready  = sel_q ? d1_ready  : d0_ready;
  assign sel_rvalid = sel_q ? d1_rvalid : d0_rvalid;
  assign sel_rdata  = sel_q ? d1_rdata  : d0_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    d0_valid   = 1'b0;
    d1_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = misaligned ? RESP : ISSUE;
      end
      ISSUE: begin
        d0_valid = !sel_q;
        d1_valid = sel_q;
        // a dead target must not hold off the timeout, even if it accepts late
        if (timeout)        state_next = RESP;
        else if (sel_ready) state_next = WAIT;
      end
      WAIT: begin
        if (sel_rvalid || timeout) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            sel_q   <= sel;
            cnt     <= '0;
            rdata_q <= ERR_RDATA;
            err_q   <= misaligned;
          end
        end
        ISSUE: begin
          if (timeout) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // completion beats a timeout landing in the same cycle
          if (sel_rvalid) begin
            rdata_q <= sel_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign d0_addr   = addr_q;
  assign d0_we     = we_q;
  assign d0_wdata  = wdata_q;
  assign d0_wstrb  = wstrb_q;
  assign d1_addr   = addr_q;
  assign d1_we     = we_q;
  assign d1_wdata  = wdata_q;
  assign d1_wstrb  = wstrb_q;

endmodule
